// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_serializer
// Purpose  : Accepts one WORD_SIZE-bit word over a valid/ready handshake and
//            emits it as N = WORD_SIZE/8 bytes, LSB byte first, one byte per
//            accepted cycle. Counts the ones of each word as its bytes leave.
//            Back-to-back words are sent with no bubble between them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional build macro:
//   SER_PRBS_EN - adds input prbs_en and a PRBS-31 (x^31 + x^28 + 1) source.
//                 While prbs_en is high the word input is ignored and the
//                 block emits endless N-byte PRBS frames with unchanged
//                 framing (byte_last / word_ones / word_ones_valid).
// ----------------------------------------------------------------------------
// Ports:
//   clk             in   1          clock, rising edge
//   rst_n           in   1          asynchronous reset, active low
//   word_data       in   WORD_SIZE  word to serialize
//   word_valid      in   1          word_data is valid
//   word_ready      out  1          a word is accepted this cycle
//   byte_data       out  8          current output byte
//   byte_valid      out  1          byte_data is valid
//   byte_ready      in   1          downstream accepts the byte
//   byte_last       out  1          current byte is byte N-1 of its word
//   word_ones       out  ONES_W     ones count of the last completed word
//   word_ones_valid out  1          one-cycle pulse when word_ones updates
//   busy            out  1          a word is being sent
//   prbs_en         in   1          (SER_PRBS_EN only) select PRBS frames
// ============================================================================
module word_serializer #(
  parameter int WORD_SIZE = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_SIZE-1:0]         word_data,
  input  logic                         word_valid,
  output logic                         word_ready,
  output logic [7:0]                   byte_data,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic                         byte_last,
  output logic [$clog2(WORD_SIZE):0]   word_ones,
  output logic                         word_ones_valid,
  output logic                         busy
`ifdef SER_PRBS_EN
  ,
  input  logic                         prbs_en
`endif
);

  localparam int N      = WORD_SIZE / 8;
  localparam int CNT_W  = $clog2(N);
  localparam int ONES_W = $clog2(WORD_SIZE) + 1;

  // Reject illegal word sizes at elaboration time.
  generate
    if ((WORD_SIZE % 8) != 0 || WORD_SIZE < 16) begin : g_bad_word_size
      $error("word_serializer: WORD_SIZE must be a multiple of 8 and >= 16");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ONES_W-1:0]    acc_q, acc_d;
  logic [ONES_W-1:0]    ones_q, ones_d;
  logic                 ones_vld_q, ones_vld_d;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

  logic       w_send;
  logic       w_last;
  logic       w_byte_fire;
  logic       w_word_fire;
  logic       w_window;
  logic [7:0] w_byte;
  logic [3:0] w_byte_ones;
  logic       w_prbs_req;   // a PRBS frame is requested at this decision point
  logic       w_prbs_mode;  // the frame in flight is a PRBS frame

`ifdef SER_PRBS_EN
  // --------------------------------------------------------------------------
  // PRBS-31 source (Fibonacci form). The output bit of each step is the MSB;
  // the first bit produced lands in byte bit 0.
  // --------------------------------------------------------------------------
  logic [30:0] lfsr_q, lfsr_d;
  logic        prbs_mode_q, prbs_mode_d;
  logic [7:0]  w_prbs_byte;
  logic [30:0] w_lfsr_adv;

  function automatic logic [30:0] lfsr_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  always_comb begin
    logic [30:0] s;
    s           = lfsr_q;
    w_prbs_byte = '0;
    for (int i = 0; i < 8; i++) begin
      w_prbs_byte[i] = s[30];
      s              = lfsr_step(s);
    end
    w_lfsr_adv = s;
  end

  assign w_prbs_req  = prbs_en;
  assign w_prbs_mode = prbs_mode_q;
  assign w_byte      = prbs_mode_q ? w_prbs_byte : shift_q[7:0];
`else
  assign w_prbs_req  = 1'b0;
  assign w_prbs_mode = 1'b0;
  assign w_byte      = shift_q[7:0];
`endif

  // --------------------------------------------------------------------------
  // Combinational outputs and handshakes
  // --------------------------------------------------------------------------
  assign w_send      = (state_q == ST_SEND);
  assign w_last      = w_send && (cnt_q == CNT_W'(N - 1));
  assign w_byte_fire = w_send && byte_ready;
  assign w_byte_ones = popcount8(w_byte);

  // Words are taken in IDLE, or on the edge that retires the last byte so
  // the next word follows without a bubble.
  assign w_window    = (state_q == ST_IDLE) || (w_send && w_last && byte_ready);
  assign word_ready  = w_window && !w_prbs_req;
  assign w_word_fire = word_valid && word_ready;

  assign byte_data       = w_byte;
  assign byte_valid      = w_send;
  assign byte_last       = w_last;
  assign busy            = w_send;
  assign word_ones       = ones_q;
  assign word_ones_valid = ones_vld_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ones_d     = ones_q;
    ones_vld_d = 1'b0;
`ifdef SER_PRBS_EN
    lfsr_d      = lfsr_q;
    prbs_mode_d = prbs_mode_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (w_prbs_req) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef SER_PRBS_EN
          prbs_mode_d = 1'b1;
`endif
        end else if (w_word_fire) begin
          state_d = ST_SEND;
          shift_d = word_data;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end

      ST_SEND: begin
        if (w_byte_fire) begin
`ifdef SER_PRBS_EN
          if (w_prbs_mode) begin
            lfsr_d = w_lfsr_adv;
          end
`endif
          if (!w_last) begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q + CNT_W'(1);
            acc_d   = acc_q + ONES_W'(w_byte_ones);
          end else begin
            // Word complete: publish the count and choose what follows.
            ones_d     = acc_q + ONES_W'(w_byte_ones);
            ones_vld_d = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
            if (w_prbs_req) begin
              state_d = ST_SEND;
`ifdef SER_PRBS_EN
              prbs_mode_d = 1'b1;
`endif
            end else if (w_word_fire) begin
              state_d = ST_SEND;
              shift_d = word_data;
`ifdef SER_PRBS_EN
              prbs_mode_d = 1'b0;
`endif
            end else begin
              state_d = ST_IDLE;
`ifdef SER_PRBS_EN
              prbs_mode_d = 1'b0;
`endif
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ones_q     <= '0;
      ones_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ones_q     <= ones_d;
      ones_vld_q <= ones_vld_d;
    end
  end

`ifdef SER_PRBS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= 31'h7FFF_FFFF;
      prbs_mode_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      prbs_mode_q <= prbs_mode_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_serializer
// Purpose  : Directed self-checking bench for word_serializer (WORD_SIZE=256).
//            Covers reset, single word, backpressure, back-to-back words,
//            reset mid-word and a random-word ones-count cross-check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_serializer;

  localparam int WS = 256;
  localparam int N  = WS / 8;

  logic              clk;
  logic              rst_n;
  logic [WS-1:0]     word_data;
  logic              word_valid;
  logic              word_ready;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;
  logic [8:0]        word_ones;
  logic              word_ones_valid;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WS-1:0] w_in [0:1];
  int            exp_ones [0:1];

  word_serializer #(.WORD_SIZE(WS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .word_data       (word_data),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .byte_last       (byte_last),
    .word_ones       (word_ones),
    .word_ones_valid (word_ones_valid),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WS-1:0] rand_word();
    logic [WS-1:0] w;
    for (int i = 0; i < WS / 32; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Feeds w_in[0..nw-1] back to back (word_valid held while words remain)
  // and checks the byte stream, stall stability and the ones pulses.
  // mode 0: byte_ready always 1; mode 1: byte_ready pattern 1,0,0,1,0,0,...
  // Entered and left at posedge+1.
  task automatic run_words(input string tag, input int nw, input int mode, input int budget);
    int fed, idx, pulses, vcyc, acc_cyc, first_v, b, wi;
    logic       stalled;
    logic [7:0] pd;
    logic       pl;
    logic [WS-1:0] cur;
    fed = 0; idx = 0; pulses = 0; vcyc = 0; acc_cyc = -1; first_v = -1;
    stalled = 1'b0; pd = '0; pl = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      word_valid = (fed < nw);
      word_data  = (fed < nw) ? w_in[fed] : rand_word();
      byte_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge clk);
      if (stalled) begin
        check({tag, ":stall_valid"}, byte_valid, 1);
        check({tag, ":stall_data"},  byte_data,  pd);
        check({tag, ":stall_last"},  byte_last,  pl);
      end
      if (byte_valid) begin
        vcyc++;
        if (first_v < 0) first_v = cyc;
      end
      if (byte_valid && byte_ready) begin
        if (idx < nw * N) begin
          b   = idx % N;
          wi  = idx / N;
          cur = w_in[wi];
          check($sformatf("%s:byte%0d", tag, idx), byte_data, cur[8*b +: 8]);
          check($sformatf("%s:last%0d", tag, idx), byte_last, (b == N - 1));
        end else begin
          check({tag, ":extra_byte"}, idx, nw * N - 1);
        end
        idx++;
      end
      stalled = byte_valid && !byte_ready;
      pd      = byte_data;
      pl      = byte_last;
      if (word_ones_valid) begin
        if (pulses < nw) check($sformatf("%s:ones%0d", tag, pulses), word_ones, exp_ones[pulses]);
        pulses++;
      end
      if (word_valid && word_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        fed++;
      end
      @(posedge clk); #1;
      if (pulses >= nw && idx >= nw * N) break;
    end
    word_valid = 1'b0;
    byte_ready = 1'b1;
    check({tag, ":transfers"}, idx, nw * N);
    check({tag, ":pulses"}, pulses, nw);
    check({tag, ":latency"}, first_v, acc_cyc + 1);
    if (mode == 0) check({tag, ":no_bubble"}, vcyc, nw * N);
    @(negedge clk);
    check({tag, ":pulse_single"}, word_ones_valid, 0);
    check({tag, ":idle_valid"}, byte_valid, 0);
    check({tag, ":idle_busy"}, busy, 0);
    check({tag, ":ones_hold"}, word_ones, exp_ones[nw-1]);
    check({tag, ":idle_ready"}, word_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    word_data  = '0;
    word_valid = 1'b0;
    byte_ready = 1'b0;

    // 1. Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst:byte_valid", byte_valid, 0);
    check("rst:busy", busy, 0);
    check("rst:word_ones", word_ones, 0);
    check("rst:word_ready", word_ready, 1);
    check("rst:ones_valid", word_ones_valid, 0);
    check("rst:byte_last", byte_last, 0);
    @(posedge clk); #1;

    // 2. Single word: 0xFF in byte 0, rest zero
    w_in[0] = '0;
    w_in[0][7:0] = 8'hFF;
    exp_ones[0] = 8;
    run_words("single", 1, 0, 100);

    // 3. Backpressure: all 0xA5
    w_in[0] = {N{8'hA5}};
    exp_ones[0] = 128;
    run_words("bp", 1, 1, 300);

    // 4. Back-to-back: all 0x00 then all 0x01
    w_in[0] = {N{8'h00}};
    w_in[1] = {N{8'h01}};
    exp_ones[0] = 0;
    exp_ones[1] = 32;
    run_words("b2b", 2, 0, 200);

    // 5. Reset after the 10th byte transfer of an all-0xFF word
    word_data  = {N{8'hFF}};
    word_valid = 1'b1;
    byte_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (byte_valid && byte_ready) n++;
      @(posedge clk); #1;
      word_valid = 1'b0;
      if (n == 10) break;
    end
    check("midrst:transfers", n, 10);
    rst_n = 1'b0;
    #1;
    check("midrst:byte_valid", byte_valid, 0);
    check("midrst:busy", busy, 0);
    check("midrst:word_ones", word_ones, 0);
    check("midrst:byte_last", byte_last, 0);
    @(negedge clk);
    check("midrst:no_pulse", word_ones_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst:no_pulse_after", word_ones_valid, 0);
    @(posedge clk); #1;
    // Byte k carries k+1, so a wrong start byte shows up immediately.
    for (int k = 0; k < N; k++) w_in[0][8*k +: 8] = 8'(k + 1);
    exp_ones[0] = 81;
    run_words("restart", 1, 0, 100);

    // 6. Random word, ones count cross-check
    w_in[0] = rand_word();
    exp_ones[0] = $countones(w_in[0]);
    run_words("rand", 1, 1, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Takes one WORD_SIZE-bit word over a valid/ready interface and emits it as WORD_SIZE/8 bytes, one byte per accepted cycle.
- Its byte output is the source side of the 8-bit `input_data` stream consumed by static_ctrl.
- Counts the ones in each word as its bytes leave, so a loopback bench can cross-check static_ctrl's `ones` output.

Parameters:
- WORD_SIZE, 256: word width in bits. Must be a multiple of 8 and at least 16. N = WORD_SIZE/8 bytes per word.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- word_data  in  WORD_SIZE  word to serialize
- word_valid  in  1  word_data is valid
- word_ready  out  1  serializer accepts a word this cycle
- byte_data  out  8  current output byte
- byte_valid  out  1  byte_data is valid
- byte_ready  in  1  downstream accepts the byte
- byte_last  out  1  current byte is byte N-1 of its word
- word_ones  out  $clog2(WORD_SIZE)+1  ones count of the last completed word
- word_ones_valid  out  1  one-cycle pulse when word_ones updates
- busy  out  1  a word is being sent (state SEND)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All state is held in flops reset by rst_n.
- Reset values:
  - state = IDLE
  - shift register, byte_data, byte_cnt, ones accumulator, word_ones = 0
  - byte_valid, byte_last, word_ones_valid, busy = 0
- Handshakes:
  - Word transfer occurs when word_valid && word_ready at a rising edge.
  - Byte transfer occurs when byte_valid && byte_ready at a rising edge.
- States:
  - IDLE: word_ready = 1, byte_valid = 0. On a word transfer: load the shift register with word_data, set byte_cnt = 0, clear the accumulator, go to SEND.
  - SEND: byte_valid = 1, byte_data = shift_reg[7:0], byte_last = (byte_cnt == N-1).
- SEND, on a byte transfer that is not the last byte:
  - Shift the register right by 8.
  - byte_cnt increments.
  - Accumulator += popcount(byte_data).
- SEND, on the last byte transfer:
  - word_ones <= accumulator + popcount(byte_data).
  - word_ones_valid pulses high for the next cycle only.
  - If word_valid is high in the same cycle, the next word is loaded and state stays SEND. This gives zero-bubble back-to-back words.
  - Otherwise state goes to IDLE.
- word_ready is combinational: (state == IDLE) || (state == SEND && byte_last && byte_ready).
- Byte order: LSB byte first. Byte k = word[8k+7 : 8k].
- Latency: a word accepted at edge t drives its first byte_valid in cycle t+1.
- Backpressure: while byte_valid && !byte_ready, byte_data, byte_last and byte_cnt hold stable.
- byte_valid never deasserts before its transfer completes, except on reset.
- word_ones cannot overflow: its width holds the value WORD_SIZE. It holds its value until the next word completes.
- Reset mid-word:
  - The partially sent word is discarded, with no word_ones_valid pulse.
  - Outputs return to reset values asynchronously.
  - The first word after reset is sent from byte 0.
- word_data is sampled only on a word transfer. Later changes to word_data are ignored.

Optional Feature:
- Macro: SER_PRBS_EN.
- Defined:
  - Adds input port `prbs_en` (1 bit) and an internal PRBS-31 LFSR, x^31+x^28+1, reset seed 31'h7FFFFFFF.
  - While prbs_en = 1, word_ready = 0 and the word input is ignored.
  - The block produces endless N-byte frames. Each byte is the next 8 LFSR output bits, LSB = oldest bit. The LFSR advances 8 steps per byte transfer.
  - byte_last, word_ones and word_ones_valid keep the same framing as normal operation.
  - prbs_en is sampled only in IDLE or at a frame boundary. A frame in progress always completes.
- Not defined: no prbs_en port and no LFSR; behaviour is exactly as above.

Test Plan (WORD_SIZE = 256, N = 32):
1. Reset: hold rst_n = 0 for 2 cycles. Then byte_valid = 0, busy = 0, word_ones = 0, word_ready = 1.
2. Single word, word_data = 256'hFF in byte 0 and all other bytes 0x00, byte_ready = 1.
   - First byte_valid is one cycle after acceptance; bytes are 0xFF then 31×0x00.
   - byte_last is high only on the 32nd byte.
   - word_ones = 8 with word_ones_valid pulsed once. State then returns to IDLE.
3. Backpressure: all-0xA5 word, byte_ready toggling 1,0,0,1,...
   - byte_data and byte_last are stable during every stall.
   - Exactly 32 transfers of 0xA5; word_ones = 128.
4. Back-to-back: word_valid held high with all-0x00 then all-0x01 words, byte_ready = 1.
   - 64 consecutive byte_valid cycles with no bubble.
   - word_ones = 0, then 32, each with one pulse.
5. Reset mid-word: assert rst_n = 0 after the 10th byte transfer of an all-0xFF word.
   - byte_valid drops immediately, with no word_ones_valid pulse.
   - The next word starts at byte 0.
6. Loopback: feed byte_data into static_ctrl input_data on transfers of a random word.
   - After 32 transfers, static_ctrl `ones` equals word_ones.
